dcache_responder: RTL and testbench
===================================

# dcache_responder

Direct-mapped, write-through, no-write-allocate data cache that services the MEM stage's data-memory request port (address, write data, write size, read/write/flush strobes) and answers with read data plus a `data_valid` completion flag. It sits between the MEM stage and a backing word-addressed memory, and reaches that memory through a single-outstanding req/ack handshake. MEM stalls while its request is pending and `data_valid_OUT` is low.

## Interface
- `LINES`, 16: number of cache lines (power of 2).
- `WORDS_PER_LINE`, 4: 32-bit words per line (power of 2).
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `data_address_IN` in 32: byte address. Reads are word-aligned; writes may be unaligned.
- `data_write_IN` in 32: store data, right-justified (N bytes live in the low N bytes).
- `data_write_size_IN` in 2: store byte count. 0 = 4, 1 = 1, 2 = 2, 3 = 3.
- `MemRead_IN`, `MemWrite_IN`, `MemFlush_IN` in 1 each: request strobes. They are held stable until `data_valid_OUT`.
- `data_read_OUT` out 32: aligned big-endian word. Byte offset 0 is [31:24].
- `data_valid_OUT` out 1: request is complete this cycle (combinational).
- `mem_addr_OUT` out 32: backing byte address.
- `mem_wdata_OUT` out 32: backing store data, same format as `data_write_IN`.
- `mem_wsize_OUT` out 2: backing store size, same encoding.
- `mem_req_OUT`, `mem_we_OUT` out 1: backing request and write-enable.
- `mem_rdata_IN` in 32: backing read word.
- `mem_ack_IN` in 1: one-cycle completion pulse from backing memory.

## Operation
- Address fields: byte offset [1:0], word offset [log2 W + 1:2], index (next log2 L bits), tag (the remaining upper bits). Defaults: word [3:2], index [7:4], tag [31:8].
- Request priority: Flush > Write > Read.
- **IDLE, no request:** `data_valid_OUT` = 1 and `data_read_OUT` = 0.
- **IDLE, read hit:** `data_valid_OUT` = 1 in the same cycle, and `data_read_OUT` = the cached word.
- **IDLE, read miss:** go to REFILL.
- **REFILL:** issue `WORDS_PER_LINE` backing reads to line word 0, 1, 2, … in order.
  - Each `mem_ack_IN` writes `mem_rdata_IN` into the data array.
  - After the last ack, set the tag and valid bit, then return to IDLE. The request then hits.
  - `data_valid_OUT` stays 0 throughout REFILL.
- **IDLE, write (hit or miss):** go to WRITE.
- **WRITE:** issue one backing write with the request's address, data and size.
  - On `mem_ack_IN`, if the line is a hit, merge the bytes into the cached word. A miss does not allocate.
  - Assert `data_valid_OUT` combinationally in the ack cycle, then return to IDLE.
- **Write merge rule:** a write of N bytes at byte offset b covers bytes b..min(b+N,4)−1.
  - Data comes from the low N bytes of the write data, most significant first.
  - Bytes that would fall past offset 3 are dropped.
- **IDLE, flush:** go to FLUSH.
- **FLUSH:** clear one valid bit per cycle, index 0 → LINES−1.
  - `data_valid_OUT` = 1 in the cycle that clears index LINES−1; the next state is IDLE.
  - No backing traffic is needed because the cache is write-through.
- **Backing handshake:**
  - `mem_req_OUT` and its addr/data/we/size are registered and held until `mem_ack_IN` is sampled high.
  - `mem_req_OUT` drops in the cycle after the ack, unless the next REFILL beat re-asserts it with the next address.
  - An ack while `mem_req_OUT` = 0 is ignored.
- **Reset (including mid-REFILL, mid-WRITE or mid-FLUSH):**
  - State returns to IDLE and all valid bits clear.
  - The beat counter and flush counter clear.
  - All `mem_*` outputs go to 0.
  - The data and tag arrays are not reset.
  - A partially refilled line stays invalid.

## Timing
- Read hit: 0 extra cycles (`data_valid_OUT` in the request cycle).
- Read miss: 1 (IDLE→REFILL) + the sum over beats of the ack latencies, + 1 cycle for the hit in IDLE.
- Write: 1 + ack latency. `data_valid_OUT` is asserted in the ack cycle.
- Flush: 1 + LINES cycles (17 at the defaults).
- Reset values: every registered output is 0. `data_valid_OUT` is 1 and `data_read_OUT` is 0 while reset is held (IDLE with no request).

## Structure
- `dcache_pkg` holds:
  - the state enum: IDLE, REFILL, WRITE, FLUSH;
  - the size-encoding constants (SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2, SZ_TRI=3);
  - the field-width functions of LINES and WORDS_PER_LINE.
- One combinational sub-module, `dcache_write_merge` (old word, data, size, byte offset → new word), is instantiated once.

## Test plan
- Reset, then read 0x0000_1000 with backing word 0x1122_3344 and 2-cycle acks. Required: 4 backing reads at 0x1000/04/08/0C; `data_valid_OUT` first high 10 cycles after the request; data = 0x1122_3344. An immediate re-read of 0x1004 is valid in the same cycle.
- After that fill, store size 1, data 0xAB, address 0x1001. Required: one backing write (0x1001, 0xAB, size 1); a subsequent read of 0x1000 returns 0x11AB_3344.
- Store size 3, data 0x00CC_DDEE, address 0x1002 on a hit. Required: the cached word becomes 0x1122_CCDD (byte EE dropped), and exactly one backing write is issued.
- Write miss to 0x2000. Required: backing write issued, no refill, and a subsequent read of 0x2000 misses (REFILL entered).
- Flush after filling lines 0 and 1. Required: `data_valid_OUT` high 17 cycles after the request; both lines then miss.
- Assert RESET mid-REFILL after 2 beats. Required: `mem_req_OUT` = 0 immediately; a stray ack is ignored; re-reading the same line does a full 4-beat refill.

Source files
------------

// File: rtl/dcache_responder_pkg.sv
// Shared types and field-width helpers for the direct-mapped write-through data cache.
// No logic of its own; latency not applicable.
// No flow control of its own; consumers handle the backing-memory handshake.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    // Store byte-count encoding: 0 means a full word.
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_TRI  = 2'd3;

    function automatic int word_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is what remains above byte, word and index fields of a 32-bit address.
    function automatic int tag_bits(input int lines, input int words_per_line);
        return 32 - 2 - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// MEM-stage request port and backing-memory port of the data cache.
// Pure wiring; no latency.
// MEM side stalls on data_valid_OUT low; backing side is single-outstanding req/ack.
interface dcache_cpu_if;
    logic [31:0] data_address_IN;
    logic [31:0] data_write_IN;
    logic [1:0]  data_write_size_IN;
    logic        MemRead_IN;
    logic        MemWrite_IN;
    logic        MemFlush_IN;
    logic [31:0] data_read_OUT;
    logic        data_valid_OUT;

    modport master (
        output data_address_IN, data_write_IN, data_write_size_IN,
        output MemRead_IN, MemWrite_IN, MemFlush_IN,
        input  data_read_OUT, data_valid_OUT
    );

    modport slave (
        input  data_address_IN, data_write_IN, data_write_size_IN,
        input  MemRead_IN, MemWrite_IN, MemFlush_IN,
        output data_read_OUT, data_valid_OUT
    );
endinterface

interface dcache_mem_if;
    logic [31:0] mem_addr_OUT;
    logic [31:0] mem_wdata_OUT;
    logic [1:0]  mem_wsize_OUT;
    logic        mem_req_OUT;
    logic        mem_we_OUT;
    logic [31:0] mem_rdata_IN;
    logic        mem_ack_IN;

    modport master (
        output mem_addr_OUT, mem_wdata_OUT, mem_wsize_OUT, mem_req_OUT, mem_we_OUT,
        input  mem_rdata_IN, mem_ack_IN
    );

    modport slave (
        input  mem_addr_OUT, mem_wdata_OUT, mem_wsize_OUT, mem_req_OUT, mem_we_OUT,
        output mem_rdata_IN, mem_ack_IN
    );
endinterface

// File: rtl/dcache_responder_write_merge.sv
// Merges right-justified store bytes into a big-endian cached word at a byte offset.
// Purely combinational, zero latency.
// No flow control; bytes that would land past offset 3 are dropped.
module dcache_write_merge
    import dcache_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] new_word_o
);
    logic [2:0] nbytes;
    logic [2:0] src_byte;

    // Lane k (offset k, bits [31-8k -: 8]) takes source byte N-1-(k-off) when covered.
    always_comb begin
        nbytes     = (size_i == SZ_WORD) ? 3'd4 : {1'b0, size_i};
        src_byte   = '0;
        new_word_o = old_word_i;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= {1'b0, off_i}) && (3'(k) < ({1'b0, off_i} + nbytes))) begin
                src_byte = nbytes - 3'd1 - (3'(k) - {1'b0, off_i});
                new_word_o[31-8*k -: 8] = wdata_i[8*src_byte[1:0] +: 8];
            end
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through no-write-allocate data cache for the MEM stage.
// Read hit 0 extra cycles; miss 1 + per-beat ack latencies + 1; write 1 + ack latency; flush 1 + LINES.
// MEM stalls while data_valid_OUT is low; backing memory holds one outstanding req until ack.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master bmem
);
    localparam int WB = word_bits(WORDS_PER_LINE);
    localparam int IB = index_bits(LINES);
    localparam int TB = tag_bits(LINES, WORDS_PER_LINE);

    state_e           state_q;
    logic [WB-1:0]    beat_q;
    logic [IB-1:0]    flush_q;
    logic [LINES-1:0] valid_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [1:0]       mem_wsize_q;

    // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
    logic [TB-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS_PER_LINE];

    // Fields of the incoming MEM-stage address.
    logic [WB-1:0]    req_word;
    logic [IB-1:0]    req_idx;
    logic [TB-1:0]    req_tag;
    logic             req_hit;
    logic [31:0]      rd_word;

    // Fields of the address currently out on the backing port.
    logic [WB-1:0]    bk_word;
    logic [IB-1:0]    bk_idx;
    logic [TB-1:0]    bk_tag;
    logic             bk_hit;

    logic             ack_take;
    logic             fill_we;
    logic             fill_last;
    logic             merge_we;
    logic [31:0]      merge_d;

    assign req_word = cpu.data_address_IN[WB+1:2];
    assign req_idx  = cpu.data_address_IN[WB+2 +: IB];
    assign req_tag  = cpu.data_address_IN[31 -: TB];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_word  = data_q[{req_idx, req_word}];

    assign bk_word  = mem_addr_q[WB+1:2];
    assign bk_idx   = mem_addr_q[WB+2 +: IB];
    assign bk_tag   = mem_addr_q[31 -: TB];
    assign bk_hit   = valid_q[bk_idx] && (tag_q[bk_idx] == bk_tag);

    // An ack only counts while a request is actually outstanding.
    assign ack_take  = bmem.mem_ack_IN && mem_req_q;
    assign fill_we   = (state_q == REFILL) && ack_take;
    assign fill_last = fill_we && (beat_q == WB'(WORDS_PER_LINE - 1));
    assign merge_we  = (state_q == WRITE) && ack_take && bk_hit;

    assign bmem.mem_req_OUT   = mem_req_q;
    assign bmem.mem_we_OUT    = mem_we_q;
    assign bmem.mem_addr_OUT  = mem_addr_q;
    assign bmem.mem_wdata_OUT = mem_wdata_q;
    assign bmem.mem_wsize_OUT = mem_wsize_q;

    dcache_write_merge u_merge (
        .old_word_i (data_q[{bk_idx, bk_word}]),
        .wdata_i    (mem_wdata_q),
        .size_i     (mem_wsize_q),
        .off_i      (mem_addr_q[1:0]),
        .new_word_o (merge_d)
    );

    // Completion flag and read data; flush and write take priority over read.
    always_comb begin
        cpu.data_valid_OUT = 1'b0;
        cpu.data_read_OUT  = '0;
        case (state_q)
            IDLE: begin
                if (!cpu.MemFlush_IN && !cpu.MemWrite_IN) begin
                    if (!cpu.MemRead_IN) begin
                        cpu.data_valid_OUT = 1'b1;
                    end else if (req_hit) begin
                        cpu.data_valid_OUT = 1'b1;
                        cpu.data_read_OUT  = rd_word;
                    end
                end
            end
            WRITE:   cpu.data_valid_OUT = ack_take;
            FLUSH:   cpu.data_valid_OUT = (flush_q == IB'(LINES - 1));
            default: cpu.data_valid_OUT = 1'b0;
        endcase
    end

    // Refill beats and store hits write the data array; the tag lands with the last beat.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_q[{bk_idx, bk_word}] <= bmem.mem_rdata_IN;
        end else if (merge_we) begin
            data_q[{bk_idx, bk_word}] <= merge_d;
        end
        if (fill_last) begin
            tag_q[bk_idx] <= bk_tag;
        end
    end

    // Main controller: state, counters, valid bits and the registered backing request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            flush_q     <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wsize_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu.MemFlush_IN) begin
                        state_q <= FLUSH;
                        flush_q <= '0;
                    end else if (cpu.MemWrite_IN) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cpu.data_address_IN;
                        mem_wdata_q <= cpu.data_write_IN;
                        mem_wsize_q <= cpu.data_write_size_IN;
                    end else if (cpu.MemRead_IN && !req_hit) begin
                        state_q     <= REFILL;
                        beat_q      <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {cpu.data_address_IN[31:WB+2], {WB{1'b0}}, 2'b00};
                        mem_wdata_q <= '0;
                        mem_wsize_q <= SZ_WORD;
                    end
                end
                REFILL: begin
                    if (ack_take) begin
                        if (fill_last) begin
                            mem_req_q       <= 1'b0;
                            valid_q[bk_idx] <= 1'b1;
                            beat_q          <= '0;
                            state_q         <= IDLE;
                        end else begin
                            // Next beat re-issues immediately with the following word address.
                            beat_q                <= beat_q + WB'(1);
                            mem_addr_q[WB+1:2]    <= beat_q + WB'(1);
                        end
                    end
                end
                WRITE: begin
                    if (ack_take) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                FLUSH: begin
                    valid_q[flush_q] <= 1'b0;
                    if (flush_q == IB'(LINES - 1)) begin
                        flush_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        flush_q <= flush_q + IB'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          chk;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        we;
    } txn_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_fail;

    dcache_cpu_if cif();
    dcache_mem_if mif();

    dcache_responder #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .cpu   (cif),
        .bmem  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference state ----------------
    logic [31:0] mem_store [int unsigned];
    txn_t        mlog [$];
    exp_t        exp_q [$];
    bit          m_valid [16];
    logic [23:0] m_tag [16];
    int          mem_lat;
    bit          stray_req;
    bit          req_active;
    bit          done;
    int          issue_cyc;

    function automatic logic [31:0] get_word(input logic [31:0] wa);
        if (mem_store.exists(int'(wa))) return mem_store[int'(wa)];
        return (wa * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    // Backing-memory store: N right-justified bytes go to offsets off.., MSB first, none past 3.
    function automatic logic [31:0] tb_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
        logic [7:0] by [4];
        int n;
        n = (sz == 2'd0) ? 4 : int'(sz);
        for (int i = 0; i < 4; i++) by[i] = old[31-8*i -: 8];
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 4) by[int'(off) + i] = d[8*(n-1-i) +: 8];
        return {by[0], by[1], by[2], by[3]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[a[7:4]] = 1'b1;
        m_tag[a[7:4]]   = a[31:8];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- backing memory ----------------
    initial begin
        mif.mem_ack_IN   = 1'b0;
        mif.mem_rdata_IN = '0;
        begin
            int cnt;
            cnt = 0;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    mif.mem_ack_IN = 1'b0;
                    cnt = 0;
                end else begin
                    if (mif.mem_ack_IN) begin
                        mif.mem_ack_IN = 1'b0;
                        cnt = 0;
                    end
                    if (stray_req && !mif.mem_req_OUT) begin
                        mif.mem_ack_IN = 1'b1;
                        stray_req = 1'b0;
                    end else if (mif.mem_req_OUT) begin
                        cnt++;
                        if (cnt >= mem_lat) begin
                            txn_t t;
                            t.addr  = mif.mem_addr_OUT;
                            t.wdata = mif.mem_wdata_OUT;
                            t.size  = mif.mem_wsize_OUT;
                            t.we    = mif.mem_we_OUT;
                            mlog.push_back(t);
                            if (t.we)
                                mem_store[int'(t.addr >> 2)] =
                                    tb_merge(get_word(t.addr >> 2), t.wdata, t.size, t.addr[1:0]);
                            else
                                mif.mem_rdata_IN = get_word(t.addr >> 2);
                            mif.mem_ack_IN = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (req_active && !done && cif.data_valid_OUT) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got completion, required none pending");
                end else begin
                    exp_t e;
                    int   lat;
                    e   = exp_q.pop_front();
                    lat = cyc - issue_cyc + 1;
                    chk({e.name, "_latency"}, lat, e.lat);
                    if (e.chk) chk({e.name, "_data"}, cif.data_read_OUT, e.data);
                end
                done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [31:0] xd, input int xl,
                         input bit cd, input string nm);
        exp_t e;
        int   n;
        e.data = xd; e.lat = xl; e.chk = cd; e.name = nm;
        exp_q.push_back(e);
        cif.data_address_IN    = a;
        cif.data_write_IN      = d;
        cif.data_write_size_IN = sz;
        cif.MemRead_IN         = (op == 0);
        cif.MemWrite_IN        = (op == 1);
        cif.MemFlush_IN        = (op == 2);
        done       = 1'b0;
        issue_cyc  = cyc;
        req_active = 1'b1;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, required one", nm, n);
            exp_q.delete();
        end
        req_active      = 1'b0;
        cif.MemRead_IN  = 1'b0;
        cif.MemWrite_IN = 1'b0;
        cif.MemFlush_IN = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] xd, input int xl, input string nm);
        issue(0, a, 32'h0, 2'd0, xd, xl, 1'b1, nm);
        model_fill(a);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                      input int xl, input string nm);
        issue(1, a, d, sz, 32'h0, xl, 1'b0, nm);
    endtask

    task automatic fl(input string nm);
        issue(2, 32'h0, 32'h0, 2'd0, 32'h0, 17, 1'b0, nm);
        model_clear();
    endtask

    initial begin
        int base;
        int n;
        n_vec = 0; n_fail = 0; cyc = 0;
        stray_req = 1'b0; req_active = 1'b0; done = 1'b0; mem_lat = 2;
        rst_n = 1'b0;
        cif.data_address_IN = '0; cif.data_write_IN = '0; cif.data_write_size_IN = '0;
        cif.MemRead_IN = 1'b0; cif.MemWrite_IN = 1'b0; cif.MemFlush_IN = 1'b0;
        model_clear();
        mem_store[32'h1000 >> 2] = 32'h1122_3344;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", cif.data_valid_OUT, 1);
        chk("rst_rdata", cif.data_read_OUT, 0);
        chk("rst_req", mif.mem_req_OUT, 0);
        chk("rst_we", mif.mem_we_OUT, 0);
        chk("rst_addr", mif.mem_addr_OUT, 0);
        rst_n = 1'b1;
        tick();

        // Read miss, four beats, then hit on a neighbour word
        mlog.delete();
        rd(32'h1000, 32'h1122_3344, 10, "miss_1000");
        chk("refill_beats", mlog.size(), 4);
        for (int i = 0; i < 4 && i < mlog.size(); i++) begin
            chk("refill_addr", mlog[i].addr, 32'h1000 + 4 * i);
            chk("refill_we", mlog[i].we, 0);
        end
        rd(32'h1004, get_word(32'h1004 >> 2), 1, "hit_1004");
        chk("hit_no_traffic", mlog.size(), 4);

        // Three-byte store at offset 2 on a hit: last byte falls off the word
        mlog.delete();
        wr(32'h1002, 32'h00CC_DDEE, 2'd3, 3, "wr_tri");
        chk("wr_tri_count", mlog.size(), 1);
        if (mlog.size() > 0) chk("wr_tri_addr", mlog[0].addr, 32'h1002);
        rd(32'h1000, 32'h1122_CCDD, 1, "rd_after_tri");

        // Single-byte store at offset 1
        mlog.delete();
        wr(32'h1001, 32'h0000_00AB, 2'd1, 3, "wr_byte");
        chk("wr_byte_count", mlog.size(), 1);
        if (mlog.size() > 0) begin
            chk("wr_byte_addr", mlog[0].addr, 32'h1001);
            chk("wr_byte_data", mlog[0].wdata, 32'hAB);
            chk("wr_byte_size", mlog[0].size, 1);
            chk("wr_byte_we", mlog[0].we, 1);
        end
        rd(32'h1000, 32'h11AB_CCDD, 1, "rd_after_byte");

        // Write miss does not allocate
        mlog.delete();
        wr(32'h2000, 32'hCAFE_F00D, 2'd0, 3, "wr_miss");
        tick();
        chk("wr_miss_count", mlog.size(), 1);
        rd(32'h2000, 32'hCAFE_F00D, 10, "rd_after_wr_miss");

        // Flush with lines 0 and 1 filled
        rd(32'h2010, get_word(32'h2010 >> 2), 10, "fill_line1");
        rd(32'h2014, get_word(32'h2014 >> 2), 1, "hit_line1");
        mlog.delete();
        fl("flush");
        chk("flush_no_traffic", mlog.size(), 0);
        rd(32'h2000, 32'hCAFE_F00D, 10, "post_flush_l0");
        rd(32'h2010, get_word(32'h2010 >> 2), 10, "post_flush_l1");

        // Reset in the middle of a refill
        base = mlog.size();
        cif.data_address_IN = 32'h3000;
        cif.MemRead_IN = 1'b1;
        n = 0;
        while (mlog.size() < base + 2 && n < 100) begin tick(); n++; end
        chk("midrefill_reach", (n < 100), 1);
        tick();
        chk("midrefill_req_pre", mif.mem_req_OUT, 1);
        rst_n = 1'b0;
        #1;
        chk("midrefill_req", mif.mem_req_OUT, 0);
        chk("midrefill_addr", mif.mem_addr_OUT, 0);
        chk("midrefill_we", mif.mem_we_OUT, 0);
        cif.MemRead_IN = 1'b0;
        model_clear();
        #1;
        chk("rst_hold_valid", cif.data_valid_OUT, 1);
        tick();
        rst_n = 1'b1;
        tick();
        stray_req = 1'b1;
        tick();
        tick();
        chk("stray_req", mif.mem_req_OUT, 0);
        chk("stray_valid", cif.data_valid_OUT, 1);
        chk("stray_no_log", mlog.size(), base + 2);
        rd(32'h3000, get_word(32'h3000 >> 2), 10, "refill_after_rst");
        chk("refill_after_rst_beats", mlog.size(), base + 6);

        // Randomized traffic against the reference model
        for (int k = 0; k < 160; k++) begin
            int          op;
            logic [31:0] a;
            mem_lat = $urandom_range(1, 3);
            op = $urandom_range(0, 99);
            a  = 32'h3000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 3) << 4)
                 + ($urandom_range(0, 3) << 2);
            if (op < 4) begin
                fl("rnd_flush");
            end else if (op < 40) begin
                logic [1:0] off;
                off = 2'($urandom_range(0, 3));
                wr(a | {30'h0, off}, $urandom, 2'($urandom_range(0, 3)), 1 + mem_lat, "rnd_wr");
            end else begin
                rd(a, get_word(a >> 2), model_hit(a) ? 1 : 2 + 4 * mem_lat, "rnd_rd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

endmodule
